// File: rtl/mips_div_pkg.sv
// Shared types and widths for the DIV/DIVU execution unit.
package mips_div_pkg;

    localparam int unsigned DIV_W = 32;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned MSB_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ITERATE,
        FIXUP,
        DONE
    } div_state_t;

endpackage

// File: rtl/mips_div_unit_msb.sv
// Leading-one encoder: bit index of the highest set bit (0 when the input is zero).
module mips_div_unit_msb
    import mips_div_pkg::*;
(
    input  logic [DIV_W-1:0] value_i,
    output logic [MSB_W-1:0] msb_o
);

    always_comb begin
        msb_o = '0;
        for (int unsigned i = 0; i < DIV_W; i++) begin
            if (value_i[i]) begin
                msb_o = MSB_W'(i);
            end
        end
    end

endmodule

// File: rtl/mips_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: quotient to LO, remainder to HI.
// Leading zeros of the dividend magnitude are skipped when EARLY_TERM is set.
module mips_div_unit
    import mips_div_pkg::*;
#(
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state_q, state_d;
    logic [DIV_W-1:0] dvd_abs_q, dvd_abs_d;
    logic [DIV_W-1:0] dvs_abs_q, dvs_abs_d;
    logic [DIV_W-1:0] dvd_raw_q, dvd_raw_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [DIV_W-1:0] q_q, q_d;
    logic [DIV_W-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [MSB_W-1:0] msb;
    logic [MSB_W-1:0] msb_sel;
    logic [DIV_W:0]   r_shift;
    logic [DIV_W-1:0] q_shift;
    logic             fits;

    mips_div_unit_msb u_msb (
        .value_i (dvd_abs_q),
        .msb_o   (msb)
    );

    // One restoring step: shift {R,Q} left and trial-subtract the divisor.
    always_comb begin
        msb_sel = EARLY_TERM ? msb : MSB_W'(DIV_W - 1);
        r_shift = {r_q, q_q[DIV_W-1]};
        q_shift = {q_q[DIV_W-2:0], 1'b0};
        fits    = (r_shift >= {1'b0, dvs_abs_q});
    end

    always_comb begin
        state_d   = state_q;
        dvd_abs_d = dvd_abs_q;
        dvs_abs_d = dvs_abs_q;
        dvd_raw_d = dvd_raw_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        q_d       = q_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_abs_d = (is_signed && dividend[DIV_W-1]) ? -dividend : dividend;
                    dvs_abs_d = (is_signed && divisor[DIV_W-1])  ? -divisor  : divisor;
                    dvd_raw_d = dividend;
                    neg_quo_d = is_signed && (dividend[DIV_W-1] ^ divisor[DIV_W-1]);
                    neg_rem_d = is_signed && dividend[DIV_W-1];
                    state_d   = ALIGN;
                end
            end
            ALIGN: begin
                if (dvs_abs_q == '0) begin
                    quo_d   = '1;
                    rem_d   = dvd_raw_q;
                    dbz_d   = 1'b1;
                    state_d = DONE;
                end else if (dvd_abs_q == '0) begin
                    q_d     = '0;
                    r_d     = '0;
                    state_d = FIXUP;
                end else begin
                    q_d     = dvd_abs_q << (MSB_W'(DIV_W - 1) - msb_sel);
                    r_d     = '0;
                    cnt_d   = CNT_W'(msb_sel) + CNT_W'(1);
                    state_d = ITERATE;
                end
            end
            ITERATE: begin
                q_d   = {q_shift[DIV_W-1:1], fits};
                r_d   = fits ? DIV_W'(r_shift - {1'b0, dvs_abs_q}) : r_shift[DIV_W-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                quo_d   = neg_quo_q ? -q_q : q_q;
                rem_d   = neg_rem_q ? -r_q : r_q;
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dvd_abs_q <= '0;
            dvs_abs_q <= '0;
            dvd_raw_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_abs_q <= dvd_abs_d;
            dvs_abs_q <= dvs_abs_d;
            dvd_raw_q <= dvd_raw_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            q_q       <= q_d;
            r_q       <= r_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_div_unit.sv
// Bench for mips_div_unit: early-terminating and full-length instances share
// stimulus; an arithmetic reference model predicts every output on every cycle.
module tb_mips_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;

    logic [1:0]  busy_w;
    logic [1:0]  done_w;
    logic [1:0]  dbz_w;
    logic [31:0] quo_w [2];
    logic [31:0] rem_w [2];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    mips_div_unit #(.EARLY_TERM(1'b1)) dut_et (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy_w[0]),
        .done        (done_w[0]),
        .quotient    (quo_w[0]),
        .remainder   (rem_w[0]),
        .div_by_zero (dbz_w[0])
    );

    mips_div_unit #(.EARLY_TERM(1'b0)) dut_full (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy_w[1]),
        .done        (done_w[1]),
        .quotient    (quo_w[1]),
        .remainder   (rem_w[1]),
        .div_by_zero (dbz_w[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", name, idx, cyc, act, exp);
        end
    endtask

    // Reference: magnitudes divided with plain integer arithmetic, signs restored after.
    function automatic void model(input bit et, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output bit z, output int lat);
        longint unsigned ma, mb, qq, rr;
        bit na, nb;
        int bits;
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? (64'h1_0000_0000 - 64'(a)) : 64'(a);
        mb = nb ? (64'h1_0000_0000 - 64'(b)) : 64'(b);
        q = '0; r = '0; z = 1'b0; lat = 3;
        if (b == 32'd0) begin
            q = '1; r = a; z = 1'b1; lat = 2;
        end else if (ma != 0) begin
            qq = ma / mb;
            rr = ma % mb;
            q = (na != nb) ? 32'(64'h1_0000_0000 - qq) : 32'(qq);
            r = na ? 32'(64'h1_0000_0000 - rr) : 32'(rr);
            bits = 0;
            for (longint unsigned t = ma; t != 0; t = t >> 1) bits++;
            lat = 3 + (et ? bits : 32);
        end
    endfunction

    bit          armed = 1'b0;
    bit          m_active [2];
    int          m_done_at [2];
    logic [31:0] m_new_q [2], m_new_r [2], m_held_q [2], m_held_r [2];
    bit          m_new_z [2], m_held_z [2];
    logic [31:0] c_q, c_r, e_q, e_r;
    bit          c_z, e_z, e_done, idle_now;
    int          c_lat;

    // Per-cycle compare against the model, then advance the model from this cycle's inputs.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            e_done = m_active[i] && (cyc == m_done_at[i]);
            e_q = e_done ? m_new_q[i] : m_held_q[i];
            e_r = e_done ? m_new_r[i] : m_held_r[i];
            e_z = e_done ? m_new_z[i] : m_held_z[i];
            if (armed) begin
                chk("busy", i, 32'(busy_w[i]), 32'(m_active[i]));
                chk("done", i, 32'(done_w[i]), 32'(e_done));
                chk("quotient", i, quo_w[i], e_q);
                chk("remainder", i, rem_w[i], e_r);
                chk("div_by_zero", i, 32'(dbz_w[i]), 32'(e_z));
            end
            idle_now = !m_active[i];
            if (e_done) begin
                m_held_q[i] = m_new_q[i];
                m_held_r[i] = m_new_r[i];
                m_held_z[i] = m_new_z[i];
                m_active[i] = 1'b0;
            end
            if (reset) begin
                m_active[i] = 1'b0;
                m_held_q[i] = '0;
                m_held_r[i] = '0;
                m_held_z[i] = 1'b0;
            end else if (start && idle_now) begin
                model(i == 0, is_signed, dividend, divisor, c_q, c_r, c_z, c_lat);
                m_new_q[i]   = c_q;
                m_new_r[i]   = c_r;
                m_new_z[i]   = c_z;
                m_done_at[i] = cyc + c_lat;
                m_active[i]  = 1'b1;
            end
        end
        if (reset) armed = 1'b1;
    end

    task automatic launch(input bit sgn, input logic [31:0] a, input logic [31:0] b, output int t);
        int guard;
        guard = 0;
        @(posedge clk); #2;
        while ((busy_w != 2'b00 || done_w != 2'b00) && guard < 100) begin
            @(posedge clk); #2;
            guard++;
        end
        chk("idle_before_start", 0, 32'(guard < 100), 32'd1);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        t         = cyc;
        @(posedge clk); #2;
        start     = 1'b0;
        is_signed = 1'($urandom);
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    task automatic wait_both(output int da, output int db);
        da = -1;
        db = -1;
        for (int k = 0; k < 80 && (da < 0 || db < 0); k++) begin
            @(negedge clk);
            if (done_w[0] && da < 0) da = cyc;
            if (done_w[1] && db < 0) db = cyc;
        end
        chk("done_seen", 0, 32'(da >= 0), 32'd1);
        chk("done_seen", 1, 32'(db >= 0), 32'd1);
    endtask

    task automatic directed(input string nm, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                            input int la, input int lb, input logic [31:0] eq, input logic [31:0] er, input bit ez);
        int t, da, db;
        launch(sgn, a, b, t);
        wait_both(da, db);
        chk({nm, "_lat"}, 0, 32'(da - t), 32'(la));
        chk({nm, "_lat"}, 1, 32'(db - t), 32'(lb));
        for (int i = 0; i < 2; i++) begin
            chk({nm, "_q"}, i, quo_w[i], eq);
            chk({nm, "_r"}, i, rem_w[i], er);
            chk({nm, "_z"}, i, 32'(dbz_w[i]), 32'(ez));
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3, 4:    v = $urandom >> $urandom_range(0, 31);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] pq, pr, ra, rb;
        bit          pz, rs;
        int          pl, t, da, db, pulses;

        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;

        // Hand-computed values that pin the reference model itself.
        model(1'b1, 1'b0, 32'd100, 32'd7, pq, pr, pz, pl);
        chk("model_100_7_q", 0, pq, 32'd14);
        chk("model_100_7_r", 0, pr, 32'd2);
        chk("model_100_7_lat", 0, 32'(pl), 32'd10);
        model(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, pq, pr, pz, pl);
        chk("model_ovf_q", 0, pq, 32'h8000_0000);
        chk("model_ovf_lat", 0, 32'(pl), 32'd35);
        model(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, pq, pr, pz, pl);
        chk("model_neg_r", 0, pr, 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        directed("divu_100_7",  1'b0, 32'd100,        32'd7,        10, 35, 32'd14,        32'd2,        1'b0);
        directed("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,         6, 35, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        directed("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 35, 35, 32'h8000_0000, 32'd0,        1'b0);
        directed("divu_1_1",    1'b0, 32'd1,          32'd1,         4, 35, 32'd1,         32'd0,        1'b0);
        directed("divu_5_0",    1'b0, 32'd5,          32'd0,         2,  2, 32'hFFFF_FFFF, 32'd5,        1'b1);
        directed("divu_0_9",    1'b0, 32'd0,          32'd9,         3,  3, 32'd0,         32'd0,        1'b0);

        // A second start while busy must be ignored.
        launch(1'b0, 32'd1000, 32'd3, t);
        repeat (3) begin @(posedge clk); #2; end
        dividend = 32'd7; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_both(da, db);
        chk("restart_lat", 0, 32'(da - t), 32'd13);
        chk("restart_lat", 1, 32'(db - t), 32'd35);
        chk("restart_q", 0, quo_w[0], 32'd333);
        chk("restart_r", 1, rem_w[1], 32'd1);

        // Reset mid-operation aborts with no done pulse and cleared outputs.
        launch(1'b0, 32'hFFFF_FFFF, 32'd3, t);
        repeat (4) begin @(posedge clk); #2; end
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
            chk("rst_q", i, quo_w[i], 32'd0);
            chk("rst_r", i, rem_w[i], 32'd0);
        end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_w != 2'b00) pulses++;
        end
        chk("rst_no_done", 0, 32'(pulses), 32'd0);

        // Random operations; some add a start pulse in the early unit's DONE cycle.
        for (int n = 0; n < 150; n++) begin
            rs = 1'($urandom);
            ra = rand_operand();
            rb = rand_operand();
            model(1'b1, rs, ra, rb, pq, pr, pz, pl);
            launch(rs, ra, rb, t);
            if ($urandom_range(0, 2) == 0) begin
                while (cyc < t + pl) begin @(posedge clk); #2; end
                start = 1'b1;
                @(posedge clk); #2;
                start = 1'b0;
            end
        end

        wait_both(da, db);
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
